// File: rtl/ram_upload_reader.sv
// HPS upload reader: halts the core, then returns work-RAM bytes on the ioctl upload channel.
// Define RAM_UPLOAD_CHECKSUM_EN to return a 16-bit byte sum at addresses 2^AW and 2^AW+1.
module ram_upload_reader #(
    parameter int          AW        = 11,
    parameter int          RAM_LAT   = 1,
    parameter logic [7:0]  INDEX     = 8'd4,
    parameter logic [15:0] PAUSE_TMO = 16'hFFFF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic          pause_tmo
);

    typedef enum logic [1:0] {IDLE, PAUSE, READY, FETCH} state_t;

    localparam logic [24:0] IMG_SIZE = 25'd1 << AW;

    state_t      state, state_next;
    logic        sel, sel_q, sel_rise;
    logic [15:0] tmo_cnt;
    logic [2:0]  lat_cnt;
    logic        pend;
    logic [24:0] pend_addr;
    logic        req, in_range, tmo_hit, fetch_done;
    logic [24:0] req_addr;
    logic [7:0]  oob_byte;
`ifdef RAM_UPLOAD_CHECKSUM_EN
    logic [15:0] sum;
`endif

    assign sel      = ioctl_upload && (ioctl_index == INDEX);
    assign sel_rise = sel && !sel_q;

    // A request latched during PAUSE takes precedence over a live strobe in READY.
    always_comb begin
        req        = pend || ioctl_rd;
        req_addr   = pend ? pend_addr : ioctl_addr;
        in_range   = req_addr < IMG_SIZE;
        tmo_hit    = tmo_cnt == PAUSE_TMO - 16'd1;
        fetch_done = lat_cnt == 3'(RAM_LAT);
        oob_byte   = 8'hFF;
`ifdef RAM_UPLOAD_CHECKSUM_EN
        if (req_addr == IMG_SIZE)
            oob_byte = sum[7:0];
        else if (req_addr == IMG_SIZE + 25'd1)
            oob_byte = sum[15:8];
`endif
        state_next = state;
        case (state)
            IDLE:    if (sel_rise) state_next = PAUSE;
            PAUSE:   if (pause_ack || tmo_hit) state_next = READY;
            READY:   if (req && in_range) state_next = FETCH;
            FETCH:   if (fetch_done) state_next = READY;
            default: state_next = IDLE;
        endcase
        if (!sel)
            state_next = IDLE;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            sel_q      <= 1'b1;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            ram_addr   <= '0;
            ram_rd     <= 1'b0;
            pause_req  <= 1'b0;
            pause_tmo  <= 1'b0;
            tmo_cnt    <= '0;
            lat_cnt    <= '0;
            pend       <= 1'b0;
            pend_addr  <= '0;
`ifdef RAM_UPLOAD_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            state  <= state_next;
            sel_q  <= sel;
            ram_rd <= 1'b0;
            if (!sel) begin
                pause_req  <= 1'b0;
                ioctl_wait <= 1'b0;
                pend       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (sel_rise) begin
                        pause_req  <= 1'b1;
                        ioctl_wait <= 1'b1;
                        pause_tmo  <= 1'b0;
                        tmo_cnt    <= '0;
                        pend       <= 1'b0;
`ifdef RAM_UPLOAD_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                    PAUSE: begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                        if (ioctl_rd && !pend) begin
                            pend      <= 1'b1;
                            pend_addr <= ioctl_addr;
                        end
                        // Keep wait asserted into READY only when a request is queued.
                        if (pause_ack || tmo_hit)
                            ioctl_wait <= pend || ioctl_rd;
                        if (!pause_ack && tmo_hit)
                            pause_tmo <= 1'b1;
                    end
                    READY: if (req) begin
                        pend <= 1'b0;
                        if (in_range) begin
                            ram_addr   <= req_addr[AW-1:0];
                            ram_rd     <= 1'b1;
                            ioctl_wait <= 1'b1;
                            lat_cnt    <= '0;
                        end else begin
                            ioctl_din  <= oob_byte;
                            ioctl_wait <= 1'b0;
                        end
                    end
                    FETCH: begin
                        if (fetch_done) begin
                            ioctl_din  <= ram_q;
                            ioctl_wait <= 1'b0;
`ifdef RAM_UPLOAD_CHECKSUM_EN
                            sum        <= sum + {8'h00, ram_q};
`endif
                        end else begin
                            lat_cnt <= lat_cnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_upload_reader.sv
// Randomized self-checking bench for ram_upload_reader against a cycle-timeline model of the upload protocol.
module tb_ram_upload_reader;

    localparam int          AW        = 11;
    localparam int          RAM_LAT   = 1;
    localparam logic [7:0]  INDEX     = 8'd4;
    localparam logic [15:0] PAUSE_TMO = 16'd16;
    localparam int          IMG       = 1 << AW;
`ifdef RAM_UPLOAD_CHECKSUM_EN
    localparam logic [7:0]  CSUM_LO   = 8'h05;
    localparam logic [7:0]  CSUM_HI   = 8'h01;
`else
    localparam logic [7:0]  CSUM_LO   = 8'hFF;
    localparam logic [7:0]  CSUM_HI   = 8'hFF;
`endif

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    ram_q;
    logic          pause_req;
    logic          pause_ack;
    logic          pause_tmo;

    logic [7:0]    mem [IMG];
    logic [7:0]    pipe [RAM_LAT];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wait_cnt = 0;
    int ram_rd_count = 0;
    bit check_en = 1'b0;

    logic [7:0]    exp_din;
    logic          exp_wait;
    logic          exp_pause_req;
    logic          exp_pause_tmo;
    logic          exp_ram_rd;
    logic [AW-1:0] exp_ram_addr;
`ifdef RAM_UPLOAD_CHECKSUM_EN
    logic [15:0]   exp_sum;
`endif

    ram_upload_reader #(
        .AW(AW), .RAM_LAT(RAM_LAT), .INDEX(INDEX), .PAUSE_TMO(PAUSE_TMO)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q),
        .pause_req(pause_req), .pause_ack(pause_ack), .pause_tmo(pause_tmo)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM returns junk except exactly RAM_LAT cycles after a read.
    always @(posedge clk_sys) begin
        pipe[0] <= (ram_rd === 1'b1) ? mem[ram_addr] : 8'($urandom);
        for (int i = 1; i < RAM_LAT; i++)
            pipe[i] <= pipe[i-1];
    end
    assign ram_q = pipe[RAM_LAT-1];

    always @(posedge clk_sys)
        if (ram_rd === 1'b1) ram_rd_count++;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk_sys) begin
        if (ioctl_wait === 1'b1) wait_cnt++;
        if (check_en) begin
            checkOutput("ioctl_din",  16'(ioctl_din),  16'(exp_din));
            checkOutput("ioctl_wait", 16'(ioctl_wait), 16'(exp_wait));
            checkOutput("pause_req",  16'(pause_req),  16'(exp_pause_req));
            checkOutput("pause_tmo",  16'(pause_tmo),  16'(exp_pause_tmo));
            checkOutput("ram_rd",     16'(ram_rd),     16'(exp_ram_rd));
            checkOutput("ram_addr",   16'(ram_addr),   16'(exp_ram_addr));
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
        cyc++;
    endtask

    task automatic set_reset_exp();
        exp_din       = 8'h00;
        exp_wait      = 1'b0;
        exp_pause_req = 1'b0;
        exp_pause_tmo = 1'b0;
        exp_ram_rd    = 1'b0;
        exp_ram_addr  = '0;
    endtask

    function automatic logic [24:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return 25'(IMG + int'($urandom_range(0, 1)));
            1:       return 25'(IMG + 2 + int'($urandom_range(0, 20)));
            2:       return 25'($urandom) | 25'(IMG);
            default: return 25'($urandom_range(0, IMG - 1));
        endcase
    endfunction

    task automatic issue(input logic [24:0] addr);
        ioctl_rd   = 1'b1;
        ioctl_addr = addr;
        step();
        ioctl_rd   = 1'b0;
        ioctl_addr = 25'($urandom);
    endtask

    // Called in the cycle after the request was accepted.
    task automatic complete(input logic [24:0] addr, input bit proto_err);
        if (addr < 25'(IMG)) begin
            exp_wait     = 1'b1;
            exp_ram_rd   = 1'b1;
            exp_ram_addr = addr[AW-1:0];
            if (proto_err) begin
                ioctl_rd   = 1'b1;
                ioctl_addr = 25'($urandom_range(0, IMG - 1));
            end
            step();
            ioctl_rd   = 1'b0;
            exp_ram_rd = 1'b0;
            repeat (RAM_LAT) step();
            exp_wait = 1'b0;
            exp_din  = mem[addr[AW-1:0]];
`ifdef RAM_UPLOAD_CHECKSUM_EN
            exp_sum  = exp_sum + {8'h00, mem[addr[AW-1:0]]};
`endif
        end else begin
            exp_din = 8'hFF;
`ifdef RAM_UPLOAD_CHECKSUM_EN
            if (addr == 25'(IMG))
                exp_din = exp_sum[7:0];
            else if (addr == 25'(IMG + 1))
                exp_din = exp_sum[15:8];
`endif
            exp_wait = 1'b0;
        end
    endtask

    task automatic read_byte(input logic [24:0] addr, input bit proto_err);
        issue(addr);
        complete(addr, proto_err);
    endtask

    task automatic start_session(input bit tmo, input int d, input bit queue, input logic [24:0] qaddr);
        int p;
        p = tmo ? int'(PAUSE_TMO) : d;
        ioctl_upload = 1'b1;
        ioctl_index  = INDEX;
        step();
        exp_pause_req = 1'b1;
        exp_wait      = 1'b1;
        exp_pause_tmo = 1'b0;
`ifdef RAM_UPLOAD_CHECKSUM_EN
        exp_sum       = '0;
`endif
        for (int i = 1; i <= p; i++) begin
            if (queue && i == 1) begin
                ioctl_rd   = 1'b1;
                ioctl_addr = qaddr;
            end
            if (!tmo && i == p) pause_ack = 1'b1;
            if (tmo && i == p) checkOutput("tmo_not_yet", 16'(pause_tmo), 16'd0);
            step();
            ioctl_rd   = 1'b0;
            pause_ack  = 1'b0;
            ioctl_addr = 25'($urandom);
        end
        if (tmo) begin
            exp_pause_tmo = 1'b1;
            checkOutput("tmo_flag_set", 16'(pause_tmo), 16'd1);
        end
        exp_wait = queue;
        if (queue) begin
            step();
            complete(qaddr, 1'b0);
        end
    endtask

    task automatic end_session();
        ioctl_upload = 1'b0;
        step();
        exp_pause_req = 1'b0;
        exp_wait      = 1'b0;
        exp_ram_rd    = 1'b0;
        repeat ($urandom_range(0, 2)) step();
    endtask

    // kind 0 drops the upload mid-fetch, kind 1 resets mid-fetch.
    task automatic read_abort(input logic [24:0] addr, input int kind);
        issue(addr);
        exp_wait     = 1'b1;
        exp_ram_rd   = 1'b1;
        exp_ram_addr = addr[AW-1:0];
        if (kind == 0) ioctl_upload = 1'b0;
        else           reset = 1'b1;
        step();
        reset = 1'b0;
        if (kind == 0) begin
            exp_pause_req = 1'b0;
            exp_wait      = 1'b0;
            exp_ram_rd    = 1'b0;
        end else begin
            set_reset_exp();
        end
        repeat (4) step();
        if (kind != 0) begin
            checkOutput("rearm_blocked", 16'(pause_req), 16'd0);
            ioctl_upload = 1'b0;
            step();
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int s = 0; s < n; s++) begin
            int nreads;
            int kind;
            bit tmo;
            bit queue;
            tmo   = ($urandom_range(0, 3) == 0);
            queue = ($urandom_range(0, 1) == 1);
            start_session(tmo, int'($urandom_range(1, 8)), queue, rand_addr());
            nreads = int'($urandom_range(3, 15));
            for (int r = 0; r < nreads; r++) begin
                read_byte(rand_addr(), $urandom_range(0, 7) == 0);
                repeat ($urandom_range(0, 2)) step();
            end
            kind = int'($urandom_range(0, 3));
            if (kind == 1)      read_abort(25'($urandom_range(0, IMG - 1)), 0);
            else if (kind == 2) read_abort(25'($urandom_range(0, IMG - 1)), 1);
            else                end_session();
        end
    endtask

    initial begin
        int wc0;
        int rc0;
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_index  = INDEX;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        pause_ack    = 1'b0;
        for (int i = 0; i < IMG; i++) mem[i] = 8'($urandom);
        mem[0]  = 8'h01;
        mem[1]  = 8'h02;
        mem[2]  = 8'h03;
        mem[3]  = 8'hFF;
        mem[16] = 8'h5A;

        step();
        step();
        set_reset_exp();
        check_en = 1'b1;
        step();
        reset = 1'b0;
        repeat (10) step();
        checkOutput("idle_pause_req", 16'(pause_req), 16'd0);
        checkOutput("idle_din", 16'(ioctl_din), 16'h00);

        start_session(1'b0, 5, 1'b0, '0);
        wc0 = wait_cnt;
        read_byte(25'h010, 1'b0);
        checkOutput("read_010_din", 16'(ioctl_din), 16'h5A);
        checkOutput("read_010_wait_cycles", 16'(wait_cnt - wc0), 16'd2);
        rc0 = ram_rd_count;
        read_byte(25'(IMG + 5), 1'b0);
        checkOutput("oob_din", 16'(ioctl_din), 16'hFF);
        step();
        checkOutput("oob_no_ram_rd", 16'(ram_rd_count - rc0), 16'd0);
        end_session();

        start_session(1'b1, 0, 1'b1, 25'h010);
        checkOutput("queued_din", 16'(ioctl_din), 16'h5A);
        end_session();

        start_session(1'b0, 2, 1'b0, '0);
        for (int i = 0; i < 4; i++) read_byte(25'(i), 1'b0);
        read_byte(25'(IMG), 1'b0);
        checkOutput("csum_lo", 16'(ioctl_din), 16'(CSUM_LO));
        read_byte(25'(IMG + 1), 1'b0);
        checkOutput("csum_hi", 16'(ioctl_din), 16'(CSUM_HI));
        end_session();

        start_session(1'b0, 3, 1'b0, '0);
        read_byte(25'h010, 1'b0);
        read_abort(25'h123, 0);
        checkOutput("abort_wait", 16'(ioctl_wait), 16'd0);
        checkOutput("abort_pause_req", 16'(pause_req), 16'd0);
        checkOutput("abort_din_kept", 16'(ioctl_din), 16'h5A);

        start_session(1'b0, 4, 1'b0, '0);
        read_abort(25'h0AB, 1);
        checkOutput("reset_din", 16'(ioctl_din), 16'h00);
        checkOutput("reset_wait", 16'(ioctl_wait), 16'd0);

        ioctl_index  = INDEX + 8'd1;
        ioctl_upload = 1'b1;
        repeat (5) step();
        checkOutput("wrong_index_pause_req", 16'(pause_req), 16'd0);
        ioctl_upload = 1'b0;
        ioctl_index  = INDEX;
        step();

        applyStimulus(40);

        repeat (3) step();
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
